// File: rtl/int_formatter_pkg.sv
// int_formatter_pkg: shared ASCII constants, default char width and FSM states for int_formatter
package int_formatter_pkg;
  localparam int DEF_B = 8;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_NUL = 8'h00;
  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;
endpackage

// File: rtl/int_formatter_dabble_step.sv
// dabble_step: one double-dabble step, add-3 on nibbles >=5 then shift in one bit
module dabble_step #(
  parameter int DIGITS = 4
) (
  input  logic [DIGITS*4-1:0] bcd,
  input  logic                bit_in,
  output logic [DIGITS*4-1:0] bcd_out
);
  logic [DIGITS*4-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[i*4+:4] = (bcd[i*4+:4] >= 4'd5) ? bcd[i*4+:4] + 4'd3 : bcd[i*4+:4];
  end
  // the top BCD bit falls off: values needing it are saturated anyway
  assign bcd_out = (adj << 1) | {{(DIGITS*4-1){1'b0}}, bit_in};
endmodule

// File: rtl/int_formatter.sv
// int_formatter: iterative binary-to-ASCII decimal formatter, one bit per clock.
// Define INT_FORMATTER_BLANK_EN to replace leading zero characters with NUL.
module int_formatter
  import int_formatter_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int W = 2*B,
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIGITS*B-1:0] str,
  output logic              ovf
);
  localparam int CW = $clog2(W+1);
  localparam logic [W:0] LIMIT = (W+1)'(10**DIGITS);
  state_t state, state_n;
  logic [W-1:0] shift;
  logic [DIGITS*4-1:0] bcd, bcd_n;
  logic [CW-1:0] cnt;
  logic ovf_r, accept, last;
  logic [DIGITS*B-1:0] str_n;
  assign accept = (state == ST_IDLE) && in_valid && in_ready;
  assign last = cnt == CW'(W-1);
  assign out_valid = state == ST_DONE;
  dabble_step #(.DIGITS(DIGITS)) u_step (.bcd(bcd), .bit_in(shift[W-1]), .bcd_out(bcd_n));
  always_comb begin
    state_n = state;
    state_n = accept ? ST_CONV :
              (state == ST_CONV && last) ? ST_DONE :
              (state == ST_DONE && out_ready) ? ST_IDLE : state;
  end
`ifdef INT_FORMATTER_BLANK_EN
  logic lead;
`endif
  always_comb begin
    str_n = '0;
`ifdef INT_FORMATTER_BLANK_EN
    lead = 1'b1;
`endif
    for (int i = DIGITS-1; i >= 0; i--) begin
      str_n[i*B+:B] = ovf_r ? B'(ASCII_NINE) : B'(ASCII_ZERO) + B'(bcd_n[i*4+:4]);
`ifdef INT_FORMATTER_BLANK_EN
      lead = lead & (bcd_n[i*4+:4] == 4'd0);
      if (lead && i != 0 && !ovf_r) str_n[i*B+:B] = B'(ASCII_NUL);
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      in_ready <= 1'b0;
      shift <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf_r <= 1'b0;
      str <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      in_ready <= state_n == ST_IDLE;
      if (accept) begin
        shift <= num;
        bcd <= '0;
        cnt <= '0;
        ovf_r <= {1'b0, num} >= LIMIT;
      end else if (state == ST_CONV) begin
        shift <= shift << 1;
        bcd <= bcd_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          str <= str_n;
          ovf <= ovf_r;
        end
      end
    end
endmodule

// File: tb/tb_int_formatter.sv
// tb_int_formatter: randomized and directed checks of int_formatter against an arithmetic model
module tb_int_formatter;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] num = '0;
  logic in_ready, out_valid, ovf;
  logic [31:0] str;
  int n_checks = 0, n_fail = 0;

  int_formatter dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .out_valid(out_valid), .out_ready(out_ready), .str(str), .ovf(ovf));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_str(input int v);
    logic [31:0] s;
    if (v >= 10000) return {4{8'h39}};
    for (int i = 0; i < 4; i++) s[i*8+:8] = 8'(8'h30 + (v / (10**i)) % 10);
`ifdef INT_FORMATTER_BLANK_EN
    for (int i = 1; i < 4; i++) if (v < 10**i) s[i*8+:8] = 8'h00;
`endif
    return s;
  endfunction

  task automatic xfer(input logic [15:0] v, input int hold);
    int n, lat;
    logic [31:0] es;
    es = model_str(int'(v));
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("in_ready_before", in_ready, 1);
    num = v;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("latency", lat, 16);
    check("str", str, es);
    check("ovf", ovf, v >= 16'd10000);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      num = 16'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_str", str, es);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    check("str_kept", str, es);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_str", str, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("in_ready_pre_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_first_edge", in_ready, 1);
    xfer(16'd2333, 0);
    xfer(16'd16, 0);
    xfer(16'd0, 0);
    xfer(16'd9999, 0);
    xfer(16'd10000, 0);
    xfer(16'd65535, 0);
    xfer(16'd511, 10);
    // abort a conversion mid-flight with an asynchronous reset
    num = 16'd64;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_str", str, 0);
    check("abort_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("no_stale_valid", out_valid, 0);
    end
    xfer(16'd64, 0);
    for (int k = 0; k < 30; k++) begin
      logic [15:0] v;
      v = (k % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      xfer(v, int'($urandom_range(0, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
